// File: rtl/posit_ctrl_pkg.sv
// Shared types and sizing helpers for the posit batch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package posit_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_DONE
    } state_t;

    // Sizing is width-generic.
    // These helpers let a block derive its byte counts from its own NBITS parameter.
    function automatic int bytes_per_posit(input int nbits);
        return nbits / 8;
    endfunction

    function automatic int pair_stride(input int nbits);
        return 2 * (nbits / 8);
    endfunction

    localparam int DEFAULT_NBITS   = 32;
    localparam int BYTES_PER_POSIT = bytes_per_posit(DEFAULT_NBITS);
    localparam int PAIR_STRIDE     = pair_stride(DEFAULT_NBITS);

endpackage

// File: rtl/posit_byte_packer.sv
// Assembles a byte stream, LSB first, into a 2*NBITS word of the form {num2, num1}.
// Latency: each byte lands in the word on the clock edge where it is presented with shift_en.
// Backpressure: none; the word holds whenever shift_en is low.
// Ports: clock/reset_n (synchronous, active-low), shift_en, byte_dat in, word out.
module posit_byte_packer #(
    parameter int NBITS = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 shift_en,
    input  logic [7:0]           byte_dat,
    output logic [2*NBITS-1:0]   word
);

    // New bytes enter at the top and move down.
    // After 2*NBITS/8 shifts, the first byte sits in bits [7:0].
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            word <= '0;
        end else if (shift_en) begin
            word <= {byte_dat, word[2*NBITS-1:8]};
        end
    end

endmodule

// File: rtl/posit_batch_sequencer.sv
// Runs a posit adder over a counted batch of operand pairs: fetch from source RAM, add, store the sum.
// Latency: 2*B+1 fetch + issue + wait + B store cycles per pair (B = NBITS/8); this is 15 cycles at NBITS=32 with an always-ready, 1-cycle adder.
// Backpressure: operands are held stable with add_valid high until add_ready; the sequencer waits indefinitely for resp_valid.
// Ports: clock, reset_n (synchronous, active-low).
//        io_start/io_count/io_src_base/io_dst_base: launch controls.
//        io_rd_*: source RAM read port. io_wr_*: result RAM write port.
//        io_add_*: adder handshake. io_busy/io_completed/io_last_result: status.
module posit_batch_sequencer #(
    parameter int NBITS  = 32,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                io_start,
    input  logic [CNT_W-1:0]    io_count,
    input  logic [ADDR_W-1:0]   io_src_base,
    input  logic [ADDR_W-1:0]   io_dst_base,
    output logic [ADDR_W-1:0]   io_rd_addr,
    input  logic [7:0]          io_rd_data,
    output logic [ADDR_W-1:0]   io_wr_addr,
    output logic [7:0]          io_wr_data,
    output logic                io_wr_en,
    output logic                io_add_valid,
    input  logic                io_add_ready,
    output logic [NBITS-1:0]    io_add_num1,
    output logic [NBITS-1:0]    io_add_num2,
    input  logic                io_add_resp_valid,
    input  logic [NBITS-1:0]    io_add_result,
    output logic                io_busy,
    output logic                io_completed,
    output logic [NBITS-1:0]    io_last_result
);
    import posit_ctrl_pkg::*;

    localparam int BPP    = bytes_per_posit(NBITS);
    localparam int STRIDE = pair_stride(NBITS);
    // Fetch runs STRIDE+1 cycles: STRIDE address cycles, plus one trailing cycle to catch the last read byte.
    localparam int CYC_W  = $clog2(STRIDE + 1);

    localparam logic [CYC_W-1:0]  FETCH_END = CYC_W'(STRIDE);
    localparam logic [CYC_W-1:0]  STORE_END = CYC_W'(BPP - 1);
    localparam logic [ADDR_W-1:0] RD_STEP   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] WR_STEP   = ADDR_W'(BPP);

    state_t               state_q;
    state_t               state_d;
    logic                 start_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     idx_q;
    logic [ADDR_W-1:0]    rd_ptr_q;
    logic [ADDR_W-1:0]    wr_ptr_q;
    logic [CYC_W-1:0]     cyc_q;
    logic [NBITS-1:0]     last_q;
    logic [2*NBITS-1:0]   pair_word;
    logic [NBITS-1:0]     res_shift;

    logic start_rise;
    logic fetch_end;
    logic store_end;
    logic last_pair;
    logic pack_en;

    assign start_rise = io_start & ~start_q;
    assign fetch_end  = (cyc_q == FETCH_END);
    assign store_end  = (cyc_q == STORE_END);
    // cnt_q is never 0 while a pair is in flight.
    // idx_q therefore tops out at cnt_q-1 and cannot wrap.
    assign last_pair  = (idx_q == cnt_q - 1'b1);
    // Read data lags the address by one cycle.
    // Fetch cycle 0 therefore has nothing to capture.
    assign pack_en    = (state_q == ST_FETCH) && (cyc_q != '0);

    posit_byte_packer #(.NBITS(NBITS)) u_packer (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (pack_en),
        .byte_dat (io_rd_data),
        .word     (pair_word)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_rise) begin
                    state_d = (io_count == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_end) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (io_add_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (io_add_resp_valid) state_d = ST_STORE;
            end
            ST_STORE: begin
                if (store_end) state_d = last_pair ? ST_DONE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, pointers and captured result.
    // The edge detector resets high, so a start level that is already high at reset release does not launch.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            start_q  <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cyc_q    <= '0;
            last_q   <= '0;
        end else begin
            start_q <= io_start;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_rise) begin
                        cnt_q    <= io_count;
                        rd_ptr_q <= io_src_base;
                        wr_ptr_q <= io_dst_base;
                        idx_q    <= '0;
                        cyc_q    <= '0;
                    end
                end
                ST_FETCH: begin
                    cyc_q <= fetch_end ? '0 : cyc_q + 1'b1;
                end
                ST_WAIT: begin
                    if (io_add_resp_valid) last_q <= io_add_result;
                end
                ST_STORE: begin
                    if (store_end) begin
                        cyc_q <= '0;
                        if (!last_pair) begin
                            idx_q    <= idx_q + 1'b1;
                            rd_ptr_q <= rd_ptr_q + RD_STEP;
                            wr_ptr_q <= wr_ptr_q + WR_STEP;
                        end
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res_shift = last_q >> {cyc_q, 3'b000};

    // Outputs, decoded from the state.
    // Every strobe and address is forced to zero outside its own phase.
    always_comb begin
        io_rd_addr   = '0;
        io_wr_addr   = '0;
        io_wr_data   = '0;
        io_wr_en     = 1'b0;
        io_add_valid = 1'b0;
        io_busy      = 1'b0;
        io_completed = 1'b0;
        case (state_q)
            ST_FETCH: begin
                io_busy = 1'b1;
                if (!fetch_end) io_rd_addr = rd_ptr_q + ADDR_W'(cyc_q);
            end
            ST_ISSUE: begin
                io_busy      = 1'b1;
                io_add_valid = 1'b1;
            end
            ST_WAIT: begin
                io_busy = 1'b1;
            end
            ST_STORE: begin
                io_busy    = 1'b1;
                io_wr_en   = 1'b1;
                io_wr_addr = wr_ptr_q + ADDR_W'(cyc_q);
                io_wr_data = res_shift[7:0];
            end
            ST_DONE: begin
                io_completed = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign io_add_num1    = pair_word[NBITS-1:0];
    assign io_add_num2    = pair_word[2*NBITS-1:NBITS];
    assign io_last_result = last_q;

endmodule

// File: tb/tb_posit_batch_sequencer.sv
// Directed bench for posit_batch_sequencer, with a source RAM model and a stand-in adder.
// Expected operands and result bytes are queued as the stimulus is loaded, then popped as the DUT presents them.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_posit_batch_sequencer;

    localparam int NBITS  = 32;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                io_start;
    logic [CNT_W-1:0]    io_count;
    logic [ADDR_W-1:0]   io_src_base;
    logic [ADDR_W-1:0]   io_dst_base;
    logic [ADDR_W-1:0]   io_rd_addr;
    logic [7:0]          io_rd_data;
    logic [ADDR_W-1:0]   io_wr_addr;
    logic [7:0]          io_wr_data;
    logic                io_wr_en;
    logic                io_add_valid;
    logic                io_add_ready;
    logic [NBITS-1:0]    io_add_num1;
    logic [NBITS-1:0]    io_add_num2;
    logic                io_add_resp_valid;
    logic [NBITS-1:0]    io_add_result;
    logic                io_busy;
    logic                io_completed;
    logic [NBITS-1:0]    io_last_result;

    always #5 clock = ~clock;

    posit_batch_sequencer #(.NBITS(NBITS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .io_start          (io_start),
        .io_count          (io_count),
        .io_src_base       (io_src_base),
        .io_dst_base       (io_dst_base),
        .io_rd_addr        (io_rd_addr),
        .io_rd_data        (io_rd_data),
        .io_wr_addr        (io_wr_addr),
        .io_wr_data        (io_wr_data),
        .io_wr_en          (io_wr_en),
        .io_add_valid      (io_add_valid),
        .io_add_ready      (io_add_ready),
        .io_add_num1       (io_add_num1),
        .io_add_num2       (io_add_num2),
        .io_add_resp_valid (io_add_resp_valid),
        .io_add_result     (io_add_result),
        .io_busy           (io_busy),
        .io_completed      (io_completed),
        .io_last_result    (io_last_result)
    );

    // Stand-in adder function.
    // It returns 2.0 for 1.0 + 1.0 and a fixed scramble otherwise.
    // The sequencer only moves the result bytes, so it does not care what the arithmetic is.
    function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000;
        return (a + b) ^ 32'h5A5A_0F0F;
    endfunction

    // Source RAM with 1-cycle read latency.
    logic [7:0] src_mem [0:4095];
    always @(posedge clock) io_rd_data <= src_mem[io_rd_addr];

    // Adder: ready rises after ready_delay valid cycles; the response pulses 1 cycle after the handshake.
    int          ready_delay;
    int          wait_cnt;
    logic        resp_vld;
    logic [31:0] resp_dat;
    assign io_add_ready      = (wait_cnt >= ready_delay);
    assign io_add_resp_valid = resp_vld;
    assign io_add_result     = resp_dat;

    always @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt <= 0;
            resp_vld <= 1'b0;
            resp_dat <= '0;
        end else begin
            resp_vld <= 1'b0;
            if (io_add_valid && io_add_ready) begin
                wait_cnt <= 0;
                resp_vld <= 1'b1;
                resp_dat <= add_model(io_add_num1, io_add_num2);
            end else if (io_add_valid) begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    int          total = 0;
    int          bad = 0;
    wr_t         exp_wr[$];
    logic [63:0] exp_ops[$];
    logic [31:0] exp_last;
    int          wr_cnt;
    int          busy_falls;
    int          valid_cycles;
    logic        busy_seen;
    logic        prev_busy;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then score whatever the DUT presents.
    task automatic tick();
        wr_t e;
        @(posedge clock);
        #1;
        if (io_wr_en) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 128'(exp_wr.size()), 128'(1));
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 128'(io_wr_addr), 128'(e.addr));
                check("wr_data", 128'(io_wr_data), 128'(e.data));
            end
        end
        if (io_add_valid) begin
            valid_cycles++;
            if (exp_ops.size() == 0) begin
                check("ops_unexpected", 128'(exp_ops.size()), 128'(1));
            end else begin
                check("ops", 128'({io_add_num2, io_add_num1}), 128'(exp_ops[0]));
                if (io_add_ready) void'(exp_ops.pop_front());
            end
        end
        if (io_busy) busy_seen = 1'b1;
        if (prev_busy && !io_busy) busy_falls++;
        prev_busy = io_busy;
    endtask

    task automatic load_pair(input logic [11:0] sbase, input logic [11:0] dbase, input int k,
                             input logic [31:0] a, input logic [31:0] b);
        logic [11:0] sa;
        logic [11:0] da;
        logic [31:0] r;
        wr_t         e;
        sa = sbase + 12'(8 * k);
        da = dbase + 12'(4 * k);
        for (int j = 0; j < 4; j++) begin
            src_mem[sa + 12'(j)]     = a[8*j +: 8];
            src_mem[sa + 12'(4 + j)] = b[8*j +: 8];
        end
        r = add_model(a, b);
        exp_last = r;
        exp_ops.push_back({b, a});
        for (int j = 0; j < 4; j++) begin
            e.addr = da + 12'(j);
            e.data = r[8*j +: 8];
            exp_wr.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !io_completed; i++) tick();
        check({tag, "_done"}, 128'(io_completed), 128'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 128'({io_rd_addr, io_wr_addr, io_wr_data, io_wr_en, io_add_valid,
                                   io_busy, io_completed}), 128'(0));
        check({tag, "_dat"}, 128'({io_add_num1, io_add_num2, io_last_result}), 128'(0));
    endtask

    initial begin
        reset_n = 1'b0;
        io_start = 1'b0;
        io_count = '0;
        io_src_base = '0;
        io_dst_base = '0;
        ready_delay = 0;
        exp_last = '0;
        wr_cnt = 0;
        busy_falls = 0;
        valid_cycles = 0;
        busy_seen = 1'b0;
        prev_busy = 1'b0;
        for (int i = 0; i < 4096; i++) src_mem[i] = 8'hEE;

        // Reset state
        repeat (3) tick();
        check_all_zero("rst");
        reset_n = 1'b1;
        tick();

        // 1) Single pair, 1.0 + 1.0, with the 15-cycle latency
        load_pair(12'h000, 12'h010, 0, 32'h4000_0000, 32'h4000_0000);
        io_count = 8'd1;
        io_src_base = 12'h000;
        io_dst_base = 12'h010;
        io_start = 1'b1;
        tick();
        check("t1_busy", 128'(io_busy), 128'(1));
        repeat (14) tick();
        check("t1_cmp_early", 128'(io_completed), 128'(0));
        tick();
        check("t1_cmp", 128'(io_completed), 128'(1));
        check("t1_busy_low", 128'(io_busy), 128'(0));
        check("t1_last", 128'(io_last_result), 128'(32'h4800_0000));
        check("t1_wr_cnt", 128'(wr_cnt), 128'(4));
        check("t1_q_empty", 128'(exp_wr.size() + exp_ops.size()), 128'(0));

        // 2) Three pairs, with ready held low 5 cycles per pair
        io_start = 1'b0;
        tick();
        wr_cnt = 0;
        busy_falls = 0;
        valid_cycles = 0;
        ready_delay = 5;
        for (int k = 0; k < 3; k++) load_pair(12'h100, 12'h200, k, $urandom, $urandom);
        io_count = 8'd3;
        io_src_base = 12'h100;
        io_dst_base = 12'h200;
        io_start = 1'b1;
        tick();
        wait_done(300, "t2");
        check("t2_wr_cnt", 128'(wr_cnt), 128'(12));
        check("t2_busy_falls", 128'(busy_falls), 128'(1));
        check("t2_valid_cycles", 128'(valid_cycles), 128'(18));
        check("t2_last", 128'(io_last_result), 128'(exp_last));
        check("t2_q_empty", 128'(exp_wr.size() + exp_ops.size()), 128'(0));

        // 3) Zero-count batch from a clean reset
        reset_n = 1'b0;
        io_start = 1'b0;
        ready_delay = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("t3_cmp_pre", 128'(io_completed), 128'(0));
        wr_cnt = 0;
        busy_seen = 1'b0;
        io_count = 8'd0;
        io_start = 1'b1;
        tick();
        check("t3_cmp", 128'(io_completed), 128'(1));
        check("t3_busy", 128'(io_busy), 128'(0));
        repeat (3) tick();
        check("t3_busy_seen", 128'(busy_seen), 128'(0));
        check("t3_wr_cnt", 128'(wr_cnt), 128'(0));

        // 4) Address wrap on both RAMs
        io_start = 1'b0;
        tick();
        wr_cnt = 0;
        load_pair(12'hFFC, 12'hFFE, 0, $urandom, $urandom);
        io_count = 8'd1;
        io_src_base = 12'hFFC;
        io_dst_base = 12'hFFE;
        io_start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            logic [11:0] ea;
            ea = 12'hFFC + 12'(i);
            check("t4_rd_addr", 128'(io_rd_addr), 128'(ea));
            tick();
        end
        wait_done(100, "t4");
        check("t4_wr_cnt", 128'(wr_cnt), 128'(4));
        check("t4_q_empty", 128'(exp_wr.size() + exp_ops.size()), 128'(0));

        // 5) A start edge while busy is ignored; a clean relaunch clears completed
        io_start = 1'b0;
        tick();
        wr_cnt = 0;
        busy_falls = 0;
        load_pair(12'h300, 12'h380, 0, $urandom, $urandom);
        load_pair(12'h300, 12'h380, 1, $urandom, $urandom);
        io_count = 8'd2;
        io_src_base = 12'h300;
        io_dst_base = 12'h380;
        io_start = 1'b1;
        tick();
        repeat (3) tick();
        io_start = 1'b0;
        tick();
        io_count = 8'd5;
        io_start = 1'b1;
        tick();
        wait_done(200, "t5");
        check("t5_wr_cnt", 128'(wr_cnt), 128'(8));
        check("t5_busy_falls", 128'(busy_falls), 128'(1));
        check("t5_last", 128'(io_last_result), 128'(exp_last));
        check("t5_q_empty", 128'(exp_wr.size() + exp_ops.size()), 128'(0));
        io_start = 1'b0;
        tick();
        check("t5_cmp_sticky", 128'(io_completed), 128'(1));
        load_pair(12'h340, 12'h3C0, 0, $urandom, $urandom);
        io_count = 8'd1;
        io_src_base = 12'h340;
        io_dst_base = 12'h3C0;
        io_start = 1'b1;
        tick();
        check("t5_relaunch_cmp", 128'(io_completed), 128'(0));
        check("t5_relaunch_busy", 128'(io_busy), 128'(1));
        wait_done(100, "t5b");
        check("t5b_wr_cnt", 128'(wr_cnt), 128'(12));
        check("t5b_q_empty", 128'(exp_wr.size() + exp_ops.size()), 128'(0));

        // 6) Reset during STORE cycle 2, with start held high across reset release
        io_start = 1'b0;
        tick();
        wr_cnt = 0;
        load_pair(12'h400, 12'h480, 0, $urandom, $urandom);
        io_count = 8'd1;
        io_src_base = 12'h400;
        io_dst_base = 12'h480;
        io_start = 1'b1;
        tick();
        repeat (13) tick();
        check("t6_in_store", 128'(io_wr_en), 128'(1));
        check("t6_store_addr", 128'(io_wr_addr), 128'(12'h482));
        reset_n = 1'b0;
        tick();
        check_all_zero("t6_rst");
        exp_wr.delete();
        exp_ops.delete();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("t6_no_launch_busy", 128'(io_busy), 128'(0));
        check("t6_no_launch_cmp", 128'(io_completed), 128'(0));
        io_start = 1'b0;
        tick();
        load_pair(12'h400, 12'h480, 0, $urandom, $urandom);
        io_start = 1'b1;
        tick();
        check("t6_launch_busy", 128'(io_busy), 128'(1));
        wait_done(100, "t6");
        check("t6_last", 128'(io_last_result), 128'(exp_last));
        check("t6_q_empty", 128'(exp_wr.size() + exp_ops.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
